// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP/halt encodings and the
// redirect encoding agreed with the EX-stage branch unit.
package pipeline_pkg;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // addi x0,x0,0: the bubble placed in IF/ID on flush.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Redirect target that the branch unit uses to signal program end.
    localparam logic [31:0] HALT_PC = 32'hFFFF_FFFF;

    // pc_sel encoding driven by the branch unit.
    localparam logic PC_SEL_SEQ    = 1'b0;
    localparam logic PC_SEL_BRANCH = 1'b1;

    // True when the branch unit requests a halt. Compares all 32 target bits.
    function automatic logic is_halt_redirect(input logic pc_sel, input logic [31:0] target);
        return (pc_sel == PC_SEL_BRANCH) && (target == HALT_PC);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (to NOP, valid=0)
//   en              load d_* when high (driven by ~stall)
//   flush           synchronous load of NOP/valid=0; overrides en
//   d_pc/d_instr/d_valid   incoming fetch bundle
//   q_pc/q_instr/q_valid   registered bundle presented to decode
module if_id_reg #(
    parameter int unsigned PC_WIDTH = 9,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] d_pc,
    input  logic [31:0]         d_instr,
    input  logic                d_valid,
    output logic [PC_WIDTH-1:0] q_pc,
    output logic [31:0]         q_instr,
    output logic                q_valid
);

    // Flush keeps the slot's PC; only the instruction and valid bit are killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc    <= '0;
            q_instr <= NOP;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_instr <= NOP;
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_instr <= d_instr;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, fetch control FSM, fetch counter
// and the IF/ID register.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC and IF/ID (hazard unit)
//   pc_sel, branch_pc redirect request/target from the branch unit
//   imem_addr         current PC to instruction memory (combinational read)
//   imem_rdata        instruction at imem_addr, same cycle
//   if_id_pc/instr/valid  IF/ID contents to decode
//   flush             combinational: redirect taken this cycle (kills ID/EX)
//   halted, misalign  sticky status flags
//   fetch_count       instructions accepted into IF/ID
module if_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 9,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                pc_sel,
    input  logic [31:0]         branch_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic                if_id_valid,
    output logic                flush,
    output logic                halted,
    output logic                misalign,
    output logic [31:0]         fetch_count
);

    localparam int unsigned INSTR_BYTES = 4;

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                ifid_en_c;
    logic                ifid_flush_c;
    logic                count_inc_c;
    logic                misalign_set_c;
    logic                halt_set_c;

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and per-cycle fetch control.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ifid_en_c      = 1'b0;
        ifid_flush_c   = 1'b0;
        count_inc_c    = 1'b0;
        misalign_set_c = 1'b0;
        halt_set_c     = 1'b0;
        flush          = 1'b0;

        case (state_q)
            BOOT: begin
                // Redirect inputs are meaningless before the first fetch.
                if (!stall) begin
                    ifid_en_c   = 1'b1;
                    count_inc_c = 1'b1;
                    pc_d        = pc_q + PC_WIDTH'(INSTR_BYTES);
                    state_d     = RUN;
                end
            end
            RUN: begin
                flush = (pc_sel == PC_SEL_BRANCH);
                if (is_halt_redirect(pc_sel, branch_pc)) begin
                    ifid_flush_c = 1'b1;
                    halt_set_c   = 1'b1;
                    state_d      = HALTED;
                end else if (pc_sel == PC_SEL_BRANCH) begin
                    // Redirect wins over stall; target truncated and word-aligned.
                    ifid_flush_c   = 1'b1;
                    pc_d           = {branch_pc[PC_WIDTH-1:2], 2'b00};
                    misalign_set_c = branch_pc[1];
                end else if (!stall) begin
                    ifid_en_c   = 1'b1;
                    count_inc_c = 1'b1;
                    pc_d        = pc_q + PC_WIDTH'(INSTR_BYTES);
                end
            end
            HALTED: begin
                // Everything frozen; IF/ID already holds the bubble.
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Sticky status flags and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted      <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (halt_set_c)     halted      <= 1'b1;
            if (misalign_set_c) misalign    <= 1'b1;
            if (count_inc_c)    fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH),
        .NOP      (NOP)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ifid_en_c),
        .flush   (ifid_flush_c),
        .d_pc    (pc_q),
        .d_instr (imem_rdata),
        .d_valid (1'b1),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch rules.
module tb_if_stage;

    localparam int unsigned PW      = 9;
    localparam int unsigned PC_MOD  = 1 << PW;
    localparam logic [31:0] NOP_EXP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          pc_sel;
    logic [31:0]   branch_pc;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [PW-1:0] if_id_pc;
    logic [31:0]   if_id_instr;
    logic          if_id_valid;
    logic          flush;
    logic          halted;
    logic          misalign;
    logic [31:0]   fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int unsigned m_pc;
    logic [31:0] m_instr;
    int unsigned m_ifpc;
    bit          m_valid;
    bit          m_started;
    bit          m_halted;
    bit          m_mis;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    // Instruction memory: word content is the address shifted left by 8.
    assign imem_rdata = 32'(imem_addr) << 8;

    if_stage #(.PC_WIDTH(PW), .NOP(NOP_EXP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .branch_pc   (branch_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .flush       (flush),
        .halted      (halted),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_instr = NOP_EXP; m_ifpc = 0; m_valid = 0;
        m_started = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
    endfunction

    function automatic void model_fetch();
        m_instr = m_pc << 8;
        m_ifpc  = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 4) % PC_MOD;
        m_cnt   = m_cnt + 1;
    endfunction

    // One clock of the fetch rules applied to the sampled inputs.
    function automatic void model_step(input bit s, input bit ps, input logic [31:0] bp);
        if (m_halted) return;
        if (!m_started) begin
            if (!s) begin
                model_fetch();
                m_started = 1;
            end
            return;
        end
        if (ps && bp == 32'hFFFF_FFFF) begin
            m_halted = 1; m_instr = NOP_EXP; m_valid = 0;
        end else if (ps) begin
            m_pc    = (bp % PC_MOD) & ~32'd3;
            m_instr = NOP_EXP;
            m_valid = 0;
            if (bp[1]) m_mis = 1;
        end else if (!s) begin
            model_fetch();
        end
    endfunction

    task automatic check_regs(input string ctx);
        check({ctx, ".if_id_pc"},    32'(if_id_pc),    m_ifpc);
        check({ctx, ".if_id_instr"}, if_id_instr,      m_instr);
        check({ctx, ".if_id_valid"}, 32'(if_id_valid), 32'(m_valid));
        check({ctx, ".halted"},      32'(halted),      32'(m_halted));
        check({ctx, ".misalign"},    32'(misalign),    32'(m_mis));
        check({ctx, ".fetch_count"}, fetch_count,      m_cnt);
    endtask

    // Called at a falling edge: drive, check comb outputs, advance one cycle.
    task automatic step(input string ctx, input bit s, input bit ps, input logic [31:0] bp);
        bit exp_flush;
        stall = s; pc_sel = ps; branch_pc = bp;
        #1;
        exp_flush = ps && m_started && !m_halted;
        check({ctx, ".imem_addr"}, 32'(imem_addr), m_pc);
        check({ctx, ".flush"},     32'(flush),     32'(exp_flush));
        model_step(s, ps, bp);
        @(posedge clk);
        @(negedge clk);
        check_regs(ctx);
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({ctx, ".imem_addr"}, 32'(imem_addr), 32'd0);
        check_regs(ctx);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; pc_sel = 1'b0; branch_pc = '0;
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // Reset then run: PCs 0,4,8 and three accepted fetches.
        for (int i = 0; i < 3; i++) step("run", 0, 0, 32'h0);
        check("run.count3", fetch_count, 32'd3);
        step("run", 0, 0, 32'h0);                  // PC now 0x10

        // Redirect at PC 0x10 to 0x40.
        step("redir", 0, 1, 32'h40);
        check("redir.addr", 32'(imem_addr), 32'h40);
        step("redir.next", 0, 0, 32'h0);
        check("redir.ifpc", 32'(if_id_pc), 32'h40);

        // Stall + redirect collision.
        do_reset("rst2");
        for (int i = 0; i < 3; i++) step("pre", 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 32'h0);
        check("stall.ifpc", 32'(if_id_pc), 32'h8);
        step("stall.redir", 1, 1, 32'h20);
        check("stall.redir.addr", 32'(imem_addr), 32'h20);

        // Wrap at the top of the 9-bit address space.
        step("wrap.go", 0, 1, 32'h1F8);
        for (int i = 0; i < 4; i++) step("wrap", 0, 0, 32'h0);

        // Misaligned target with bits above PC_WIDTH.
        step("mis", 0, 1, 32'h0000_0206);
        check("mis.addr", 32'(imem_addr), 32'h004);
        for (int i = 0; i < 2; i++) step("mis.sticky", 0, 0, 32'h0);

        // Halt, then redirect pulses must be ignored.
        step("halt", 0, 1, 32'hFFFF_FFFF);
        step("halt.pulse", 0, 1, 32'h80);
        step("halt.pulse", 1, 1, 32'hFFFF_FFFF);
        step("halt.idle", 0, 0, 32'h0);

        // Mid-run asynchronous reset.
        do_reset("rst3");
        for (int i = 0; i < 5; i++) step("pre2", 0, 0, 32'h0);
        do_reset("midrun");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          s;
            bit          ps;
            logic [31:0] bp;
            s  = ($urandom_range(0, 99) < 30);
            ps = ($urandom_range(0, 99) < 12);
            bp = ($urandom_range(0, 99) < 8) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 0) bp = bp | 32'h8000_0000;
            if (bp == 32'hFFFF_FFFF && $urandom_range(0, 1) == 0) bp = 32'hFFFF_FFFF;
            step("rand", s, ps, bp);
            if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 99) == 0)
                do_reset("rand.rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the program counter and the IF/ID pipeline register.
- Consumes the EX-stage branch unit's redirect outputs (`pc_sel`, `branch_pc`) to steer fetch, flush wrong-path instructions and latch the halt condition.
- Takes stall requests from the hazard unit and presents the fetched instruction, its PC and a valid bit to decode.

## Interface
- `PC_WIDTH`, 9: width of the internal PC and instruction-memory byte address.
- `NOP`, 32'h00000013: instruction (addi x0,x0,0) inserted on flush/bubble.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: hazard unit; hold PC and IF/ID.
- `pc_sel` in 1: branch unit; 1 = redirect to `branch_pc`.
- `branch_pc` in 32: branch unit redirect target; 32'hFFFFFFFF with `pc_sel`=1 means halt.
- `imem_addr` out PC_WIDTH: current PC to instruction memory (combinational read).
- `imem_rdata` in 32: instruction at `imem_addr`, same cycle.
- `if_id_pc` out PC_WIDTH: PC of the instruction in IF/ID.
- `if_id_instr` out 32: instruction in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `flush` out 1: combinational; = `pc_sel` while in RUN. Decode uses it to bubble ID/EX.
- `halted` out 1: sticky halt indication.
- `misalign` out 1: sticky; a redirect target had bit 1 set.
- `fetch_count` out 32: number of instructions accepted into IF/ID.

## Operation
**States (`fetch_state_t`):**
- BOOT: first cycle after reset.
  - Presents PC 0.
  - IF/ID is loaded with imem_rdata, PC 0 and valid=1 unless `stall`.
  - Goes to RUN after the first load.
  - Inputs `pc_sel`/`branch_pc` are ignored in BOOT.
- RUN: normal fetch.
- HALTED: terminal until `rst_n` is asserted.
  - PC frozen.
  - IF/ID holds NOP with valid=0.
  - `flush`=0, `fetch_count` frozen.

**RUN priority per cycle (highest first):**
1. **Halt:** `pc_sel`=1 and `branch_pc`=32'hFFFFFFFF.
   - Go to HALTED; IF/ID gets NOP, valid=0; PC unchanged.
2. **Redirect:** `pc_sel`=1.
   - PC gets `branch_pc[PC_WIDTH-1:0]` with bits [1:0] forced to 00.
   - IF/ID gets NOP, valid=0.
   - If `branch_pc[1]`=1, set `misalign`.
   - A redirect overrides `stall`.
3. **Stall:** PC and IF/ID hold; counter holds.
4. **Sequential:** PC gets PC+4, modulo 2^PC_WIDTH (wraps to 0, no error).
   - IF/ID gets {`imem_rdata`, PC, valid=1}.
   - `fetch_count` increments, wrapping at 2^32.

**Width and output rules:**
- `branch_pc` bits above PC_WIDTH are discarded, except for the all-ones halt compare, which uses the full 32 bits.
- `imem_addr` = PC register, combinational.

## Timing
- Reset values:
  - PC=0, state=BOOT.
  - `if_id_instr`=NOP, `if_id_pc`=0, `if_id_valid`=0.
  - `halted`=0, `misalign`=0, `fetch_count`=0.
- Reset mid-operation returns to these values immediately (asynchronous), whatever the state.
- Fetch latency: an instruction at `imem_addr` in cycle N appears on `if_id_*` in cycle N+1.
- Redirect penalty:
  - Redirect sampled at edge N; the target is on `imem_addr` in N+1 and in IF/ID at N+2.
  - Exactly one IF/ID bubble is produced by this block; ID/EX is killed through `flush`.
- `halted` rises one cycle after the halt redirect is sampled.
- Stall held for K cycles: outputs unchanged for K cycles, no count change.

## Structure
- Shared package `pipeline_pkg`:
  - `fetch_state_t` enum {BOOT, RUN, HALTED}.
  - `NOP_INSTR` = 32'h00000013.
  - `HALT_PC` = 32'hFFFFFFFF.
  - Redirect-encoding constants shared with the branch unit.
- One sub-module: `if_id_reg`.
  - Parameterised pipeline register with enable (~stall), synchronous flush-to-NOP, and asynchronous active-low reset to NOP/valid=0.
- The PC register, state machine and counter live in `if_stage`.

## Test plan
- **Reset then run:** imem returns addr<<8.
  - Release `rst_n` → `if_id_pc` 0,4,8 on successive cycles, valid=1.
  - `fetch_count`=3 after three loads.
- **Redirect:** `pc_sel`=1, `branch_pc`=32'h40 at PC 0x10.
  - `flush`=1 that cycle.
  - Next cycle `imem_addr`=0x40 and IF/ID valid=0/NOP.
  - Following cycle `if_id_pc`=0x40.
- **Stall + redirect collision:** `stall`=1 for 3 cycles holds `if_id_pc`=0x8.
  - Asserting `pc_sel`=1, `branch_pc`=0x20 during the stall → PC=0x20, IF/ID flushed.
- **Halt:** `pc_sel`=1, `branch_pc`=32'hFFFFFFFF.
  - `halted`=1 next cycle; PC frozen; valid=0.
  - Further `pc_sel` pulses are ignored until `rst_n` low.
- **Wrap:** PC_WIDTH=9, PC=0x1FC, no stall → next PC 0x000, no error flag.
- **Misalign and truncation:** `pc_sel`=1, `branch_pc`=32'h0000_0206.
  - PC=0x004 (bit 9 dropped, bits 1:0 cleared); `misalign`=1 sticky.
  - Async reset mid-run clears all outputs without a clock edge.
